i2s_mic_capture: RTL



---
 rtl/i2s_mic_capture.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/i2s_mic_capture.sv
// i2s_mic_capture: I2S bus master for a MEMS microphone.
// Generates SCK/WS and captures the top 16 bits of one channel's 32-bit slot
// as a signed PCM sample, with a one-cycle valid strobe per frame.
// Ports:
//   clk_in          system clock (rising edge)
//   rst_in          asynchronous active-low reset
//   en_in           capture enable (level)
//   sd_in           mic serial data (asynchronous, synchronised internally)
//   sck_out         I2S bit clock
//   ws_out          I2S word select
//   audio_out       last captured signed 16-bit sample
//   audio_valid_out one-cycle strobe for a new audio_out
//   busy_out        high while running
module i2s_mic_capture #(
  parameter int unsigned CLK_DIV = 16,
  parameter int unsigned CHANNEL = 0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        en_in,
  input  logic        sd_in,
  output logic        sck_out,
  output logic        ws_out,
  output logic [15:0] audio_out,
  output logic        audio_valid_out,
  output logic        busy_out
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned BIT_W = 6;
  localparam int unsigned SMP_W = 16;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic             CH_SEL   = 1'(CHANNEL);
  localparam logic [BIT_W-1:0] BIT_START = BIT_W'(63);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_cnt, div_cnt_n;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_n, bit_inc;
  logic [SMP_W-1:0]   shift_q, shift_n;
  logic               pend, pend_n;
  logic               sck_n, ws_n, valid_n, busy_n;
  logic [SMP_W-1:0]   audio_n;
  logic               sd_meta, sd_sync;

  // Two-flop synchroniser for the mic data line
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sd_meta <= 1'b0;
      sd_sync <= 1'b0;
    end else begin
      sd_meta <= sd_in;
      sd_sync <= sd_meta;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= IDLE;
      div_cnt         <= '0;
      bit_cnt         <= BIT_START;
      shift_q         <= '0;
      pend            <= 1'b0;
      sck_out         <= 1'b0;
      ws_out          <= 1'b0;
      audio_out       <= '0;
      audio_valid_out <= 1'b0;
      busy_out        <= 1'b0;
    end else begin
      state           <= state_n;
      div_cnt         <= div_cnt_n;
      bit_cnt         <= bit_cnt_n;
      shift_q         <= shift_n;
      pend            <= pend_n;
      sck_out         <= sck_n;
      ws_out          <= ws_n;
      audio_out       <= audio_n;
      audio_valid_out <= valid_n;
      busy_out        <= busy_n;
    end
  end

  assign bit_inc = bit_cnt + BIT_W'(1);

  // Next-state, clock generation and capture
  always_comb begin
    state_n   = state;
    div_cnt_n = div_cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift_q;
    pend_n    = 1'b0;
    sck_n     = sck_out;
    ws_n      = ws_out;
    audio_n   = audio_out;
    valid_n   = 1'b0;
    busy_n    = 1'b0;

    case (state)
      IDLE: begin
        div_cnt_n = '0;
        bit_cnt_n = BIT_START;
        shift_n   = '0;
        sck_n     = 1'b0;
        ws_n      = 1'b0;
        if (en_in) begin
          state_n = RUN;
          busy_n  = 1'b1;
        end
      end

      RUN: begin
        if (!en_in) begin
          // Abort: drop the partial sample and any pending strobe
          state_n   = IDLE;
          div_cnt_n = '0;
          bit_cnt_n = BIT_START;
          shift_n   = '0;
          sck_n     = 1'b0;
          ws_n      = 1'b0;
        end else begin
          busy_n = 1'b1;
          if (pend) begin
            audio_n = shift_q;
            valid_n = 1'b1;
          end
          if (div_cnt == DIV_LAST) begin
            div_cnt_n = '0;
            sck_n     = ~sck_out;
            if (sck_out) begin
              // Falling toggle: advance bit; WS leads the slot MSB by one bit
              bit_cnt_n = bit_inc;
              ws_n      = (bit_inc >= BIT_W'(31)) && (bit_inc != BIT_W'(63));
            end else if (!bit_cnt[4] && (bit_cnt[5] == CH_SEL)) begin
              // Rising toggle inside the top 16 bits of the selected slot
              shift_n = {shift_q[SMP_W-2:0], sd_sync};
              pend_n  = (bit_cnt[3:0] == 4'd15);
            end
          end else begin
            div_cnt_n = div_cnt + DIV_W'(1);
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
